// File: rtl/agc_pkg.sv
// Shared types and constants for the AGC PWM loop: FSM state encoding, widths, step decode.
package agc_pkg;

  localparam int unsigned PWM_W = 7;
  localparam int unsigned PWR_W = 9;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StTrack = 2'd1,
    StFix   = 2'd2
  } agc_state_e;

  // Gain step in threshold LSBs: 1, 2, 4 or 8. One extra bit so loop arithmetic never wraps.
  function automatic logic [PWM_W:0] step_decode(input logic [1:0] sel);
    step_decode = (PWM_W + 1)'(1) << sel;
  endfunction

endpackage

// File: rtl/agc_pwm_core.sv
// PWM generator: free-running 7-bit period counter, compare and period-aligned threshold
// double buffer so a new threshold only takes effect at a period boundary.
module agc_pwm_core
  import agc_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [PWM_W-1:0] th_nxt_i,
  input  logic             pwm_ena_i,
  input  logic             pwm_inv_i,
  output logic             pwm_out_o,
  output logic [PWM_W-1:0] th_act_o
);

  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic [PWM_W-1:0] th_act_q, th_act_d;
  logic             pwm_out_q, pwm_out_d;
  logic             wrap;

  assign wrap = pwm_ena_i && (cnt_q == {PWM_W{1'b1}});

  always_comb begin
    cnt_d     = pwm_ena_i ? cnt_q + 1'b1 : '0;
    th_act_d  = wrap ? th_nxt_i : th_act_q;
    pwm_out_d = pwm_ena_i ? ((cnt_q < th_act_q) ^ pwm_inv_i) : pwm_inv_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      th_act_q  <= '0;
      pwm_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      th_act_q  <= th_act_d;
      pwm_out_q <= pwm_out_d;
    end
  end

  assign pwm_out_o = pwm_out_q;
  assign th_act_o  = th_act_q;

endmodule

// File: rtl/agc_pwm_loop.sv
// AGC loop: steps the PWM threshold from power estimates, tracks lock in an IDLE/TRACK/FIX FSM.
// Optional AGC_FIX_FREEZE_EN: freeze the threshold while locked and widen the unlock window.
module agc_pwm_loop
  import agc_pkg::*;
#(
  parameter logic [PWR_W-1:0] TARGET_DB = 9'd160,
  parameter logic [PWR_W-1:0] HYST_DB   = 9'd4,
  parameter int unsigned      FIX_CNT   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [PWR_W-1:0] pwr_est_dB,
  input  logic             pwr_est_end,
  input  logic             pwm_ena,
  input  logic [1:0]       pwm_step,
  input  logic             pwm_inv,
  input  logic             pwm_th_ena,
  input  logic [PWM_W-1:0] pwm_th_in,
  input  logic [PWM_W-1:0] pwm_max_val,
  output logic             pwm_out,
  output logic [PWM_W-1:0] pwm_th_out,
  output logic [PWR_W-2:0] pwr_est_val,
  output logic             agc_fix
);

  localparam int unsigned InbW = (FIX_CNT < 1) ? 1 : $clog2(FIX_CNT + 1);
  localparam logic [InbW-1:0] InbMax = InbW'(FIX_CNT);

  agc_state_e       state_q;
  logic [InbW-1:0]  inb_q, inb_inc;
  logic             agc_fix_q;
  logic [PWR_W-2:0] pwr_est_val_q;
  logic [PWM_W-1:0] th_nxt_q, th_nxt_d;
  logic [PWM_W-1:0] th_act;

  logic signed [PWR_W:0] err, hyst_s, hyst2_s;
  logic                  err_hi, err_lo, in_band, fix_exit, freeze, loop_upd;

  logic [PWM_W:0] step, th_ext, max_ext, th_inc, th_dec, th_sel;

  // Error in 10-bit signed so the full 9-bit unsigned estimate range is representable.
  assign err     = $signed({1'b0, pwr_est_dB}) - $signed({1'b0, TARGET_DB});
  assign hyst_s  = $signed({1'b0, HYST_DB});
  assign hyst2_s = hyst_s + hyst_s;
  assign err_hi  = err > hyst_s;
  assign err_lo  = err < -hyst_s;
  assign in_band = !err_hi && !err_lo;

`ifdef AGC_FIX_FREEZE_EN
  assign freeze   = (state_q == StFix);
  assign fix_exit = (err > hyst2_s) || (err < -hyst2_s);
`else
  assign freeze   = 1'b0;
  assign fix_exit = !in_band;
`endif

  assign loop_upd = pwm_ena && pwr_est_end && !freeze &&
                    ((state_q == StTrack) || (state_q == StFix));

  assign step    = step_decode(pwm_step);
  assign th_ext  = {1'b0, th_nxt_q};
  assign max_ext = {1'b0, pwm_max_val};
  assign th_inc  = th_ext + step;
  assign th_dec  = (th_ext > step) ? th_ext - step : '0;

  // Manual override wins over the loop; the final clamp also catches a lowered pwm_max_val.
  always_comb begin
    th_sel = th_ext;
    if (pwm_th_ena) begin
      th_sel = {1'b0, pwm_th_in};
    end else if (loop_upd) begin
      if (err_hi) begin
        th_sel = th_dec;
      end else if (err_lo) begin
        th_sel = th_inc;
      end
    end
    th_nxt_d = (th_sel > max_ext) ? pwm_max_val : th_sel[PWM_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      th_nxt_q      <= '0;
      pwr_est_val_q <= '0;
    end else begin
      th_nxt_q <= th_nxt_d;
      if (pwr_est_end) begin
        pwr_est_val_q <= pwr_est_dB[PWR_W-1:1];
      end
    end
  end

  assign inb_inc = (inb_q == InbMax) ? InbMax : inb_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      inb_q     <= '0;
      agc_fix_q <= 1'b0;
    end else if (!pwm_ena) begin
      state_q   <= StIdle;
      inb_q     <= '0;
      agc_fix_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_q   <= StTrack;
          inb_q     <= '0;
          agc_fix_q <= 1'b0;
        end
        StTrack: begin
          agc_fix_q <= 1'b0;
          if (pwr_est_end) begin
            if (in_band) begin
              inb_q <= inb_inc;
              if (inb_inc == InbMax) begin
                state_q   <= StFix;
                agc_fix_q <= !pwm_th_ena;
              end
            end else begin
              inb_q <= '0;
            end
          end
        end
        StFix: begin
          agc_fix_q <= !pwm_th_ena;
          if (pwr_est_end) begin
            inb_q <= in_band ? inb_inc : '0;
            if (fix_exit) begin
              state_q   <= StTrack;
              agc_fix_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          inb_q     <= '0;
          agc_fix_q <= 1'b0;
        end
      endcase
    end
  end

  agc_pwm_core u_core (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .th_nxt_i  (th_nxt_q),
    .pwm_ena_i (pwm_ena),
    .pwm_inv_i (pwm_inv),
    .pwm_out_o (pwm_out),
    .th_act_o  (th_act)
  );

  assign pwm_th_out  = th_act;
  assign pwr_est_val = pwr_est_val_q;
  assign agc_fix     = agc_fix_q;

endmodule

// File: tb/tb_agc_pwm_loop.sv
// Directed bench for agc_pwm_loop: vector table for threshold stepping plus hand sequences
// for duty, lock, period-aligned update and mid-period reset.
module tb_agc_pwm_loop;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [8:0] pwr_est_dB = '0;
  logic       pwr_est_end = 1'b0;
  logic       pwm_ena = 1'b0;
  logic [1:0] pwm_step = '0;
  logic       pwm_inv = 1'b0;
  logic       pwm_th_ena = 1'b0;
  logic [6:0] pwm_th_in = '0;
  logic [6:0] pwm_max_val = '0;
  logic       pwm_out;
  logic [6:0] pwm_th_out;
  logic [7:0] pwr_est_val;
  logic       agc_fix;

  always #5 clk = ~clk;

  agc_pwm_loop dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pwr_est_dB  (pwr_est_dB),
    .pwr_est_end (pwr_est_end),
    .pwm_ena     (pwm_ena),
    .pwm_step    (pwm_step),
    .pwm_inv     (pwm_inv),
    .pwm_th_ena  (pwm_th_ena),
    .pwm_th_in   (pwm_th_in),
    .pwm_max_val (pwm_max_val),
    .pwm_out     (pwm_out),
    .pwm_th_out  (pwm_th_out),
    .pwr_est_val (pwr_est_val),
    .agc_fix     (agc_fix)
  );

  int checks = 0;
  int errors = 0;

  localparam int KStrobe = 0;
  localparam int KLoad   = 1;
  localparam int KIdle   = 2;

  typedef struct {
    int kind;
    int db;
    int step;
    int maxv;
    int th_in;
    int exp_th;
    int exp_val;
    int exp_fix;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input int db);
    pwr_est_dB  = 9'(db);
    pwr_est_end = 1'b1;
    @(negedge clk);
    pwr_est_end = 1'b0;
  endtask

  task automatic load_th(input int th);
    pwm_th_in  = 7'(th);
    pwm_th_ena = 1'b1;
    @(negedge clk);
    pwm_th_ena = 1'b0;
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwm_out) hi++;
    end
  endtask

  // Returns on the negedge where the period counter holds 1 (first high sample of a period).
  task automatic sync_cnt1(output bit ok);
    int  n;
    bit  prev;
    n    = 0;
    ok   = 1'b0;
    prev = pwm_out;
    while (n < 400 && !ok) begin
      @(negedge clk);
      n++;
      if (pwm_out && !prev) ok = 1'b1;
      prev = pwm_out;
    end
  endtask

  int hi;
  bit ok;
  int exp_fix_mid, exp_th_mid, exp_th_end;

  initial begin
    vecs[0] = '{KLoad, 0, 2, 40, 0, 0, 0, 0};
    for (int i = 1; i <= 10; i++) vecs[i] = '{KStrobe, 100, 2, 40, 0, 4 * i, 50, 0};
    vecs[11] = '{KStrobe, 100, 2, 40, 0, 40, 50, 0};
    vecs[12] = '{KStrobe, 100, 2, 40, 0, 40, 50, 0};
    vecs[13] = '{KIdle, 0, 2, 20, 0, 20, 50, 0};
    vecs[14] = '{KLoad, 0, 3, 127, 3, 3, 50, 0};
    vecs[15] = '{KStrobe, 250, 3, 127, 0, 0, 125, 0};
    vecs[16] = '{KStrobe, 250, 3, 127, 0, 0, 125, 0};
    vecs[17] = '{KStrobe, 161, 0, 127, 0, 0, 80, 0};
    vecs[18] = '{KStrobe, 100, 0, 127, 0, 1, 50, 0};
    vecs[19] = '{KStrobe, 200, 1, 127, 0, 0, 100, 0};

`ifdef AGC_FIX_FREEZE_EN
    exp_fix_mid = 1; exp_th_mid = 20; exp_th_end = 20;
`else
    exp_fix_mid = 0; exp_th_mid = 19; exp_th_end = 18;
`endif

    // Reset state
    #2 reset_n = 1'b0;
    cyc(3);
    check("rst pwm_out", int'(pwm_out), 0);
    check("rst th_out", int'(pwm_th_out), 0);
    check("rst est_val", int'(pwr_est_val), 0);
    check("rst agc_fix", int'(agc_fix), 0);
    reset_n = 1'b1;

    // Disabled: output sits at the inversion level
    pwm_inv = 1'b1;
    cyc(2);
    check("dis pwm_out inv1", int'(pwm_out), 1);
    pwm_inv = 1'b0;
    cyc(1);
    check("dis pwm_out inv0", int'(pwm_out), 0);

    // Manual threshold duty
    pwm_max_val = 7'd127;
    pwm_th_in   = 7'd32;
    pwm_th_ena  = 1'b1;
    pwm_ena     = 1'b1;
    cyc(260);
    count_high(128, hi);
    check("duty th32", hi, 32);
    check("th_out th32", int'(pwm_th_out), 32);
    pwm_inv = 1'b1;
    cyc(2);
    count_high(128, hi);
    check("duty th32 inv", hi, 96);
    pwm_inv = 1'b0;
    cyc(2);
    check("fix held low manual", int'(agc_fix), 0);
    pwm_th_in   = 7'd100;
    pwm_max_val = 7'd50;
    cyc(130);
    check("manual clamp", int'(pwm_th_out), 50);

    // Threshold stepping table
    for (int i = 0; i < 20; i++) begin
      pwm_step    = 2'(vecs[i].step);
      pwm_max_val = 7'(vecs[i].maxv);
      case (vecs[i].kind)
        KStrobe: strobe(vecs[i].db);
        KLoad:   load_th(vecs[i].th_in);
        default: cyc(1);
      endcase
      cyc(130);
      check($sformatf("vec%0d th", i), int'(pwm_th_out), vecs[i].exp_th);
      check($sformatf("vec%0d val", i), int'(pwr_est_val), vecs[i].exp_val);
      check($sformatf("vec%0d fix", i), int'(agc_fix), vecs[i].exp_fix);
    end

    // Lock after four in-band estimates, then unlock
    pwm_step    = 2'd0;
    pwm_max_val = 7'd127;
    load_th(20);
    for (int i = 0; i < 4; i++) begin
      strobe(162);
      if (i == 2) check("fix after 3rd", int'(agc_fix), 0);
      if (i < 3) cyc(3);
    end
    check("fix after 4th", int'(agc_fix), 1);
    cyc(3);
    strobe(166);
    check("fix after 166", int'(agc_fix), exp_fix_mid);
    cyc(130);
    check("th after 166", int'(pwm_th_out), exp_th_mid);
    strobe(170);
    check("fix after 170", int'(agc_fix), 0);
    cyc(130);
    check("th after 170", int'(pwm_th_out), exp_th_end);
    check("val after 170", int'(pwr_est_val), 85);

    // Threshold change mid-period takes effect only at the wrap
    load_th(20);
    cyc(130);
    sync_cnt1(ok);
    check("sync1 found", int'(ok), 1);
    cyc(59);
    pwm_th_in  = 7'd90;
    pwm_th_ena = 1'b1;
    @(negedge clk);
    pwm_th_ena = 1'b0;
    count_high(66, hi);
    check("no glitch highs", hi, 0);
    check("th_out before wrap", int'(pwm_th_out), 20);
    cyc(1);
    check("th_out after wrap", int'(pwm_th_out), 90);
    count_high(128, hi);
    check("duty th90", hi, 90);

    // Asynchronous reset mid-period while locked
    for (int i = 0; i < 4; i++) strobe(160);
    cyc(1);
    check("fix before reset", int'(agc_fix), 1);
    sync_cnt1(ok);
    check("sync2 found", int'(ok), 1);
    cyc(69);
    reset_n = 1'b0;
    #1;
    check("async rst pwm_out", int'(pwm_out), 0);
    check("async rst th_out", int'(pwm_th_out), 0);
    check("async rst val", int'(pwr_est_val), 0);
    check("async rst fix", int'(agc_fix), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post rst fix", int'(agc_fix), 0);
    check("post rst pwm_out", int'(pwm_out), 0);
    cyc(130);
    check("post rst th_out", int'(pwm_th_out), 0);
    check("post rst fix late", int'(agc_fix), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
